// File: rtl/alu_exe.sv
// rtl/alu_exe.sv - RV64I integer ALU execute stage with E1 capture and WB result registers
module alu_exe #(
    parameter int RNBIT = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 flush,
    input  logic                 alu_execute_vaild,
    output logic                 alu_execute_ready,
    input  logic [144+RNBIT-1:0] alu_execute_info,
    output logic                 alu_writeback_vaild,
    input  logic                 alu_writeback_ready,
    output logic [5+RNBIT-1:0]   alu_writeback_rd0,
    output logic [63:0]          alu_writeback_res,
    output logic [31:0]          alu_retire_cnt
);

    localparam int RDW = 5 + RNBIT;
    localparam int IW  = 144 + RNBIT;

    logic [IW-1:0]  e1_info_q, e1_info_d;
    logic           e1_valid_q, e1_valid_d;
    logic           wb_valid_q, wb_valid_d;
    logic [RDW-1:0] wb_rd0_q, wb_rd0_d;
    logic [63:0]    wb_res_q, wb_res_d;
    logic [31:0]    retire_q, retire_d;

    logic           fun_add, fun_sub, fun_slt, fun_sll, fun_srl, fun_sra;
    logic           fun_xor, fun_or, fun_and;
    logic [RDW-1:0] e1_rd0;
    logic [63:0]    op1, op2;
    logic           is32, is_usi;

    assign {fun_add, fun_sub, fun_slt, fun_sll, fun_srl, fun_sra,
            fun_xor, fun_or, fun_and, e1_rd0, op1, op2, is32, is_usi} = e1_info_q;

    logic [5:0]  sh;
    logic [63:0] r_add, r_sub, r_sll, r_srl, r_sra, r_slt;
    logic [63:0] srl_src, sra_src, result;
    logic        lt;

    function automatic logic [63:0] sext_w(input logic [63:0] v, input logic w);
        sext_w = w ? {{32{v[31]}}, v[31:0]} : v;
    endfunction

    always_comb begin
        sh      = is32 ? {1'b0, op2[4:0]} : op2[5:0];
        srl_src = is32 ? {32'b0, op1[31:0]} : op1;
        sra_src = is32 ? {{32{op1[31]}}, op1[31:0]} : op1;
        lt      = is_usi ? (op1 < op2) : ($signed(op1) < $signed(op2));
        r_add   = sext_w(op1 + op2, is32);
        r_sub   = sext_w(op1 - op2, is32);
        r_sll   = sext_w(op1 << sh, is32);
        r_srl   = sext_w(srl_src >> sh, is32);
        r_sra   = sext_w($signed(sra_src) >>> sh, is32);
        r_slt   = {63'b0, lt};
        // One-hot select as AND-OR so illegal multi-hot encodings still give a defined value
        result  = ({64{fun_add}} & r_add) | ({64{fun_sub}} & r_sub)
                | ({64{fun_slt}} & r_slt) | ({64{fun_sll}} & r_sll)
                | ({64{fun_srl}} & r_srl) | ({64{fun_sra}} & r_sra)
                | ({64{fun_xor}} & (op1 ^ op2))
                | ({64{fun_or}}  & (op1 | op2))
                | ({64{fun_and}} & (op1 & op2));
    end

    logic wb_adv, accept, move, wb_fire;

    always_comb begin
        wb_adv            = ~wb_valid_q | alu_writeback_ready;
        alu_execute_ready = (~e1_valid_q | wb_adv) & ~flush;
        accept            = alu_execute_vaild & alu_execute_ready;
        move              = e1_valid_q & wb_adv;
        wb_fire           = wb_valid_q & alu_writeback_ready;

        e1_info_d  = accept ? alu_execute_info : e1_info_q;
        wb_rd0_d   = move ? e1_rd0 : wb_rd0_q;
        wb_res_d   = move ? result : wb_res_q;
        retire_d   = retire_q + {31'b0, wb_fire};

        e1_valid_d = e1_valid_q;
        if (flush)       e1_valid_d = 1'b0;
        else if (accept) e1_valid_d = 1'b1;
        else if (move)   e1_valid_d = 1'b0;

        wb_valid_d = wb_valid_q;
        if (flush)        wb_valid_d = 1'b0;
        else if (move)    wb_valid_d = 1'b1;
        else if (wb_fire) wb_valid_d = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            e1_info_q  <= '0;
            e1_valid_q <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_rd0_q   <= '0;
            wb_res_q   <= '0;
            retire_q   <= '0;
        end else begin
            e1_info_q  <= e1_info_d;
            e1_valid_q <= e1_valid_d;
            wb_valid_q <= wb_valid_d;
            wb_rd0_q   <= wb_rd0_d;
            wb_res_q   <= wb_res_d;
            retire_q   <= retire_d;
        end
    end

    assign alu_writeback_vaild = wb_valid_q;
    assign alu_writeback_rd0   = wb_rd0_q;
    assign alu_writeback_res   = wb_res_q;
    assign alu_retire_cnt      = retire_q;

endmodule

// File: tb/tb_alu_exe.sv
// tb/tb_alu_exe.sv - directed self-checking bench for alu_exe
module tb_alu_exe;

    localparam int RNBIT = 2;
    localparam int RDW   = 5 + RNBIT;
    localparam int IW    = 144 + RNBIT;

    localparam logic [8:0] F_ADD = 9'b100000000;
    localparam logic [8:0] F_SUB = 9'b010000000;
    localparam logic [8:0] F_SLT = 9'b001000000;
    localparam logic [8:0] F_SLL = 9'b000100000;
    localparam logic [8:0] F_SRL = 9'b000010000;
    localparam logic [8:0] F_SRA = 9'b000001000;
    localparam logic [8:0] F_XOR = 9'b000000100;
    localparam logic [8:0] F_OR  = 9'b000000010;
    localparam logic [8:0] F_AND = 9'b000000001;

    logic           CLK = 1'b0;
    logic           RST = 1'b0;
    logic           flush = 1'b0;
    logic           alu_execute_vaild = 1'b0;
    logic           alu_execute_ready;
    logic [IW-1:0]  alu_execute_info = '0;
    logic           alu_writeback_vaild;
    logic           alu_writeback_ready = 1'b0;
    logic [RDW-1:0] alu_writeback_rd0;
    logic [63:0]    alu_writeback_res;
    logic [31:0]    alu_retire_cnt;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_cnt = 0;

    alu_exe #(.RNBIT(RNBIT)) dut (
        .CLK                 (CLK),
        .RST                 (RST),
        .flush               (flush),
        .alu_execute_vaild   (alu_execute_vaild),
        .alu_execute_ready   (alu_execute_ready),
        .alu_execute_info    (alu_execute_info),
        .alu_writeback_vaild (alu_writeback_vaild),
        .alu_writeback_ready (alu_writeback_ready),
        .alu_writeback_rd0   (alu_writeback_rd0),
        .alu_writeback_res   (alu_writeback_res),
        .alu_retire_cnt      (alu_retire_cnt)
    );

    always #5 CLK = ~CLK;

    function automatic logic [IW-1:0] mk(input logic [8:0] fun, input logic [RDW-1:0] rd,
                                         input logic [63:0] a, input logic [63:0] b,
                                         input logic w, input logic u);
        mk = {fun, rd, a, b, w, u};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [IW-1:0] info,
                          input logic [RDW-1:0] exp_rd, input logic [63:0] exp_res);
        alu_writeback_ready = 1'b1;
        alu_execute_info    = info;
        alu_execute_vaild   = 1'b1;
        #1;
        check({tag, "_ready"}, {63'b0, alu_execute_ready}, 64'd1);
        tick();
        alu_execute_vaild = 1'b0;
        check({tag, "_vaild_e1"}, {63'b0, alu_writeback_vaild}, 64'd0);
        tick();
        check({tag, "_vaild_wb"}, {63'b0, alu_writeback_vaild}, 64'd1);
        check({tag, "_res"}, alu_writeback_res, exp_res);
        check({tag, "_rd0"}, {{(64-RDW){1'b0}}, alu_writeback_rd0}, {{(64-RDW){1'b0}}, exp_rd});
        tick();
        exp_cnt++;
        check({tag, "_cnt"}, {32'b0, alu_retire_cnt}, {32'b0, exp_cnt});
        check({tag, "_drained"}, {63'b0, alu_writeback_vaild}, 64'd0);
    endtask

    initial begin
        // reset
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        check("rst_vaild", {63'b0, alu_writeback_vaild}, 64'd0);
        check("rst_rd0", {57'b0, alu_writeback_rd0}, 64'd0);
        check("rst_res", alu_writeback_res, 64'd0);
        check("rst_cnt", {32'b0, alu_retire_cnt}, 64'd0);
        check("rst_ready", {63'b0, alu_execute_ready}, 64'd1);

        // arithmetic vectors
        run_op("add", mk(F_ADD, 7'h2A, 64'd5, 64'd7, 1'b0, 1'b0), 7'h2A, 64'd12);
        run_op("addw", mk(F_ADD, 7'h01, 64'h7FFFFFFF, 64'd1, 1'b1, 1'b0), 7'h01, 64'hFFFFFFFF80000000);
        run_op("srlw", mk(F_SRL, 7'h02, 64'hFFFFFFFF80000000, 64'd4, 1'b1, 1'b0), 7'h02, 64'h0000000008000000);
        run_op("sraw", mk(F_SRA, 7'h03, 64'hFFFFFFFF80000000, 64'd4, 1'b1, 1'b0), 7'h03, 64'hFFFFFFFFF8000000);
        run_op("sra", mk(F_SRA, 7'h04, 64'h8000000000000000, 64'd4, 1'b0, 1'b0), 7'h04, 64'hF800000000000000);
        run_op("slt", mk(F_SLT, 7'h05, 64'hFFFFFFFFFFFFFFFF, 64'd1, 1'b0, 1'b0), 7'h05, 64'd1);
        run_op("sltu", mk(F_SLT, 7'h06, 64'hFFFFFFFFFFFFFFFF, 64'd1, 1'b0, 1'b1), 7'h06, 64'd0);
        run_op("sll", mk(F_SLL, 7'h07, 64'd1, 64'd63, 1'b0, 1'b0), 7'h07, 64'h8000000000000000);
        run_op("sub", mk(F_SUB, 7'h08, 64'd3, 64'd5, 1'b0, 1'b0), 7'h08, 64'hFFFFFFFFFFFFFFFE);
        run_op("xor", mk(F_XOR, 7'h09, 64'hF0, 64'h3C, 1'b0, 1'b0), 7'h09, 64'hCC);
        run_op("noflag", mk(9'b0, 7'h0A, 64'd5, 64'd7, 1'b0, 1'b0), 7'h0A, 64'd0);
        run_op("or_and", mk(F_OR | F_AND, 7'h0B, 64'hF0, 64'h3C, 1'b0, 1'b0), 7'h0B, 64'hFC);

        // backpressure: four back-to-back adds of k+100
        alu_writeback_ready = 1'b0;
        alu_execute_vaild   = 1'b1;
        alu_execute_info    = mk(F_ADD, 7'd1, 64'd0, 64'd100, 1'b0, 1'b0);
        #1;
        check("bp_rdy0", {63'b0, alu_execute_ready}, 64'd1);
        tick();
        alu_execute_info = mk(F_ADD, 7'd2, 64'd1, 64'd100, 1'b0, 1'b0);
        #1;
        check("bp_rdy1", {63'b0, alu_execute_ready}, 64'd1);
        tick();
        alu_execute_info = mk(F_ADD, 7'd3, 64'd2, 64'd100, 1'b0, 1'b0);
        #1;
        check("bp_full", {63'b0, alu_execute_ready}, 64'd0);
        tick();
        check("bp_hold_rdy", {63'b0, alu_execute_ready}, 64'd0);
        check("bp_hold_v", {63'b0, alu_writeback_vaild}, 64'd1);
        check("bp_hold_res", alu_writeback_res, 64'd100);
        check("bp_hold_rd0", {57'b0, alu_writeback_rd0}, 64'd1);
        alu_writeback_ready = 1'b1;
        #1;
        check("bp_release_rdy", {63'b0, alu_execute_ready}, 64'd1);
        tick();
        check("bp_out1", alu_writeback_res, 64'd101);
        check("bp_out1_rd", {57'b0, alu_writeback_rd0}, 64'd2);
        alu_execute_info = mk(F_ADD, 7'd4, 64'd3, 64'd100, 1'b0, 1'b0);
        tick();
        alu_execute_vaild = 1'b0;
        check("bp_out2", alu_writeback_res, 64'd102);
        tick();
        check("bp_out3", alu_writeback_res, 64'd103);
        check("bp_out3_v", {63'b0, alu_writeback_vaild}, 64'd1);
        tick();
        exp_cnt += 4;
        check("bp_empty", {63'b0, alu_writeback_vaild}, 64'd0);
        check("bp_cnt", {32'b0, alu_retire_cnt}, {32'b0, exp_cnt});

        // flush with both stages full and a pending input
        alu_writeback_ready = 1'b0;
        alu_execute_vaild   = 1'b1;
        alu_execute_info    = mk(F_ADD, 7'h10, 64'd1, 64'd1, 1'b0, 1'b0);
        tick();
        alu_execute_info = mk(F_ADD, 7'h11, 64'd2, 64'd2, 1'b0, 1'b0);
        tick();
        alu_execute_info = mk(F_ADD, 7'h12, 64'd3, 64'd3, 1'b0, 1'b0);
        flush = 1'b1;
        #1;
        check("fl_ready", {63'b0, alu_execute_ready}, 64'd0);
        tick();
        flush = 1'b0;
        alu_execute_vaild = 1'b0;
        check("fl_vaild", {63'b0, alu_writeback_vaild}, 64'd0);
        check("fl_cnt", {32'b0, alu_retire_cnt}, {32'b0, exp_cnt});
        alu_writeback_ready = 1'b1;
        tick();
        tick();
        check("fl_no_ghost", {63'b0, alu_writeback_vaild}, 64'd0);
        check("fl_cnt2", {32'b0, alu_retire_cnt}, {32'b0, exp_cnt});

        // flush coinciding with a writeback handshake still retires it
        alu_execute_vaild = 1'b1;
        alu_execute_info  = mk(F_ADD, 7'h13, 64'd4, 64'd4, 1'b0, 1'b0);
        tick();
        alu_execute_vaild = 1'b0;
        tick();
        check("flhs_v", {63'b0, alu_writeback_vaild}, 64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        exp_cnt++;
        check("flhs_cnt", {32'b0, alu_retire_cnt}, {32'b0, exp_cnt});
        check("flhs_vaild", {63'b0, alu_writeback_vaild}, 64'd0);

        // reset with both stages occupied
        alu_writeback_ready = 1'b0;
        alu_execute_vaild   = 1'b1;
        alu_execute_info    = mk(F_XOR, 7'h20, 64'hAA, 64'h55, 1'b0, 1'b0);
        tick();
        alu_execute_info = mk(F_OR, 7'h21, 64'hA0, 64'h05, 1'b0, 1'b0);
        tick();
        alu_execute_vaild = 1'b0;
        check("mr_full_v", {63'b0, alu_writeback_vaild}, 64'd1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        exp_cnt = 0;
        check("mr_vaild", {63'b0, alu_writeback_vaild}, 64'd0);
        check("mr_rd0", {57'b0, alu_writeback_rd0}, 64'd0);
        check("mr_res", alu_writeback_res, 64'd0);
        check("mr_cnt", {32'b0, alu_retire_cnt}, 64'd0);
        alu_writeback_ready = 1'b1;
        tick();
        check("mr_no_ghost", {63'b0, alu_writeback_vaild}, 64'd0);
        run_op("post_rst", mk(F_AND, 7'h22, 64'hFF00, 64'h0FF0, 1'b0, 1'b0), 7'h22, 64'h0F00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
